instr_executor: RTL

Reader/execution end of the instruction register. After a start pulse it walks a contiguous address range of the 32-entry register, reads each stored `instruction_t`, computes the opcode result and presents it with its address for write-back or scoreboarding. It sits beside the register on the same clock and drives the register's read pointer.

---
 rtl/instr_register_pkg.sv | 52 +++++
 rtl/instr_executor_divider.sv | 66 ++++++
 rtl/instr_executor.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its executor.
// Latency: none, types, constants and pure helper functions only.
// Backpressure: not applicable.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] rezultat_t;
  typedef logic        [4:0]  address_t;

  typedef struct packed {
    opcode_t   opc;
    operand_t  op_a;
    operand_t  op_b;
    rezultat_t rez;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    DIVIDE = 3'd3,
    RESULT = 3'd4
  } exec_state_t;

  localparam int DIV_ITER_CYCLES = 32;

  // Magnitude of a signed operand as unsigned; -2^31 maps to 2^31 without overflow.
  function automatic logic [31:0] mag32(input operand_t v);
    logic [31:0] u;
    u = v;
    return v[31] ? (~u + 32'd1) : u;
  endfunction

  // Re-apply a sign to an unsigned 32-bit magnitude, widening to 64 bits.
  function automatic rezultat_t apply_sign(input logic [31:0] mag, input logic neg);
    logic [63:0] w;
    w = {32'b0, mag};
    return neg ? rezultat_t'(~w + 64'd1) : rezultat_t'(w);
  endfunction

endpackage

// File: rtl/instr_executor_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Latency: load cycle then DIV_ITER_CYCLES iterations; ready stays high until next load.
// Backpressure: none; caller holds results by not issuing a new load.
module iter_divider
  import instr_register_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        ready
);

  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [5:0]  r_count;
  logic        r_run;
  logic        r_done;

  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_take;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    w_shift = {r_rem, r_quo[31]};
    w_diff  = w_shift - {1'b0, r_dvs};
    w_take  = ~w_diff[32];
  end

  // Operand capture on load, then one restoring step per cycle until all bits are done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_count <= '0;
      r_run   <= 1'b0;
      r_done  <= 1'b0;
    end else if (load) begin
      r_rem   <= '0;
      r_quo   <= dividend;
      r_dvs   <= divisor;
      r_count <= '0;
      r_run   <= 1'b1;
      r_done  <= 1'b0;
    end else if (r_run) begin
      r_rem   <= w_take ? w_diff[31:0] : w_shift[31:0];
      r_quo   <= {r_quo[30:0], w_take};
      r_count <= r_count + 6'd1;
      if (r_count == 6'(DIV_ITER_CYCLES - 1)) begin
        r_run  <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign ready     = r_done;

endmodule

// File: rtl/instr_executor.sv
// Walks an address range of the instruction register and computes each result (macro INSTR_EXEC_ITER_DIV_EN selects the iterative divider).
// Latency: 3 cycles per entry; DIV/MOD take 3 cycles, or 36 with the iterative divider.
// Backpressure: none; result_valid is a one-cycle pulse and start is ignored while busy.
module instr_executor
  import instr_register_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  address_t     first_addr,
  input  address_t     last_addr,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output rezultat_t    result,
  output address_t     result_addr,
  output logic         result_valid,
  output logic         error,
  output logic         busy,
  output logic         done
);

  exec_state_t r_state;
  exec_state_t w_next_state;

  address_t    r_last;
  opcode_t     r_opc;
  operand_t    r_op_a;
  operand_t    r_op_b;

  rezultat_t   w_alu;
  logic        w_alu_err;
  rezultat_t   w_div_res;
  logic        w_div_err;
  logic        w_div_done;
  logic        w_is_div;
  logic        w_at_last;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic        w_b_zero;

  // The stored result field is not consumed by the executor.
  logic        w_unused_rez;
  assign w_unused_rez = ^instruction_word.rez;

  assign w_is_div  = (instruction_word.opc == DIV) || (instruction_word.opc == MOD);
  assign w_at_last = (read_pointer == r_last);
  assign w_mag_a   = mag32(r_op_a);
  assign w_mag_b   = mag32(r_op_b);
  assign w_b_zero  = (r_op_b == '0);

`ifdef INSTR_EXEC_ITER_DIV_EN
  logic        r_div_loaded;
  logic        w_div_load;
  logic        w_iter_ready;

  // Load is issued only in the first DIVIDE cycle; ready is trusted only after that load.
  assign w_div_load = (r_state == DIVIDE) && !r_div_loaded;
  assign w_div_done = r_div_loaded && w_iter_ready;

  iter_divider u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (w_div_load),
    .dividend  (w_mag_a),
    .divisor   (w_mag_b),
    .quotient  (w_q_mag),
    .remainder (w_r_mag),
    .ready     (w_iter_ready)
  );
`else
  logic [31:0] w_safe_b;

  // Divisor forced non-zero so the unused quotient stays defined; zero is flagged separately.
  always_comb begin
    w_safe_b = w_b_zero ? 32'd1 : w_mag_b;
    w_q_mag  = w_mag_a / w_safe_b;
    w_r_mag  = w_mag_a % w_safe_b;
  end

  assign w_div_done = 1'b1;
`endif

  // Quotient truncates toward zero, remainder follows the dividend sign, zero divisor is an error.
  always_comb begin
    w_div_res = '0;
    w_div_err = w_b_zero;
    if (!w_b_zero) begin
      if (r_opc == MOD) w_div_res = apply_sign(w_r_mag, r_op_a[31]);
      else              w_div_res = apply_sign(w_q_mag, r_op_a[31] ^ r_op_b[31]);
    end
  end

  // Single-cycle opcodes on sign-extended operands; opcodes 8-15 flag an error.
  always_comb begin
    w_alu     = '0;
    w_alu_err = 1'b0;
    case (r_opc)
      ZERO:    w_alu = '0;
      PASSA:   w_alu = rezultat_t'(r_op_a);
      PASSB:   w_alu = rezultat_t'(r_op_b);
      ADD:     w_alu = rezultat_t'(r_op_a) + rezultat_t'(r_op_b);
      SUB:     w_alu = rezultat_t'(r_op_a) - rezultat_t'(r_op_b);
      MULT:    w_alu = rezultat_t'(r_op_a) * rezultat_t'(r_op_b);
      DIV,
      MOD:     w_alu = '0;
      default: w_alu_err = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = FETCH;
      FETCH:   w_next_state = w_is_div ? DIVIDE : EXEC;
      EXEC:    w_next_state = RESULT;
      DIVIDE:  if (w_div_done) w_next_state = RESULT;
      RESULT:  w_next_state = w_at_last ? IDLE : FETCH;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    busy         = (r_state != IDLE);
    result_valid = (r_state == RESULT);
    done         = (r_state == RESULT) && w_at_last;
  end

  // Pointer, operand capture and result registers; results only change on entry to RESULT.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      read_pointer <= '0;
      r_last       <= '0;
      r_opc        <= ZERO;
      r_op_a       <= '0;
      r_op_b       <= '0;
      result       <= '0;
      result_addr  <= '0;
      error        <= 1'b0;
`ifdef INSTR_EXEC_ITER_DIV_EN
      r_div_loaded <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            read_pointer <= first_addr;
            r_last       <= last_addr;
          end
        end
        FETCH: begin
          r_opc  <= instruction_word.opc;
          r_op_a <= instruction_word.op_a;
          r_op_b <= instruction_word.op_b;
        end
        EXEC: begin
          result      <= w_alu;
          error       <= w_alu_err;
          result_addr <= read_pointer;
        end
        DIVIDE: begin
`ifdef INSTR_EXEC_ITER_DIV_EN
          r_div_loaded <= !w_div_done;
`endif
          if (w_div_done) begin
            result      <= w_div_res;
            error       <= w_div_err;
            result_addr <= read_pointer;
          end
        end
        RESULT: begin
          if (!w_at_last) read_pointer <= read_pointer + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
